xadc_drp_stream_adapter: RTL and testbench



---
 rtl/xadc_drp_stream_adapter.sv | 122 ++++++++++++
 tb/tb_xadc_drp_stream_adapter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_stream_adapter.sv
// Reads the XADC voltage and current status registers over DRP once per end-of-sequence
// and presents each sample on its own single-beat stream (latest sample wins under backpressure).
module xadc_drp_stream_adapter #(
   parameter int         DATA_WIDTH   = 16,
   parameter logic [6:0] VOLTAGE_ADDR = 7'h14,
   parameter logic [6:0] CURRENT_ADDR = 7'h1C
) (
   input  logic                  xadc_dclk,
   input  logic                  xadc_reset,
   output logic [6:0]            xadc_daddr,
   output logic                  xadc_den,
   input  logic                  xadc_drdy,
   input  logic [DATA_WIDTH-1:0] xadc_do,
   input  logic                  xadc_eos,
   output logic [DATA_WIDTH-1:0] voltage_tdata,
   output logic                  voltage_tvalid,
   input  logic                  voltage_tready,
   output logic                  voltage_tlast,
   output logic [DATA_WIDTH-1:0] current_tdata,
   output logic                  current_tvalid,
   input  logic                  current_tready,
   output logic                  current_tlast,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_V  = 3'd1,
      WAIT_V = 3'd2,
      REQ_C  = 3'd3,
      WAIT_C = 3'd4
   } state_t;

   state_t     state, state_next;
   logic       eos_pending, eos_pending_next;
   logic       den_next;
   logic [6:0] daddr_next;
   logic       cap_v, cap_c;

   always_comb begin
      state_next       = state;
      eos_pending_next = eos_pending;
      cap_v            = 1'b0;
      cap_c            = 1'b0;
      case (state)
         IDLE: begin
            if (xadc_eos || eos_pending) begin
               state_next       = REQ_V;
               eos_pending_next = 1'b0;
            end
         end
         REQ_V:  state_next = WAIT_V;
         WAIT_V: begin
            if (xadc_drdy) begin
               cap_v      = 1'b1;
               state_next = REQ_C;
            end
         end
         REQ_C:  state_next = WAIT_C;
         WAIT_C: begin
            if (xadc_drdy) begin
               cap_c      = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // An eos seen mid-sequence is remembered once; repeats collapse into it.
      if (state != IDLE && xadc_eos) eos_pending_next = 1'b1;
   end

   // den/daddr are registered from the next state so they line up with REQ_V/REQ_C.
   always_comb begin
      den_next   = (state_next == REQ_V) || (state_next == REQ_C);
      daddr_next = xadc_daddr;
      if (state_next == REQ_V) daddr_next = VOLTAGE_ADDR;
      if (state_next == REQ_C) daddr_next = CURRENT_ADDR;
   end

   always_ff @(posedge xadc_dclk or negedge xadc_reset) begin
      if (!xadc_reset) begin
         state       <= IDLE;
         eos_pending <= 1'b0;
         xadc_den    <= 1'b0;
         xadc_daddr  <= 7'd0;
      end else begin
         state       <= state_next;
         eos_pending <= eos_pending_next;
         xadc_den    <= den_next;
         xadc_daddr  <= daddr_next;
      end
   end

   // Stream handshake: a beat transfers on any edge where tvalid=1 and tready=1; tvalid
   // then drops unless a fresh capture lands on the same edge. A capture always overwrites tdata.
   always_ff @(posedge xadc_dclk or negedge xadc_reset) begin
      if (!xadc_reset) begin
         voltage_tdata  <= '0;
         voltage_tvalid <= 1'b0;
         current_tdata  <= '0;
         current_tvalid <= 1'b0;
      end else begin
         if (cap_v) begin
            voltage_tdata  <= xadc_do;
            voltage_tvalid <= 1'b1;
         end else if (voltage_tvalid && voltage_tready) begin
            voltage_tvalid <= 1'b0;
         end
         if (cap_c) begin
            current_tdata  <= xadc_do;
            current_tvalid <= 1'b1;
         end else if (current_tvalid && current_tready) begin
            current_tvalid <= 1'b0;
         end
      end
   end

   assign voltage_tlast = 1'b1;
   assign current_tlast = 1'b1;
   assign state_dbg     = state;

endmodule

// File: tb/tb_xadc_drp_stream_adapter.sv
// Directed bench for xadc_drp_stream_adapter: manual latency/reset sequences, a table of
// DRP sequences with per-channel ready settings, and a scoreboard of expected stream beats.
module tb_xadc_drp_stream_adapter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         xadc_reset;
   logic [6:0]   xadc_daddr;
   logic         xadc_den;
   logic         xadc_drdy;
   logic [W-1:0] xadc_do;
   logic         xadc_eos;
   logic [W-1:0] voltage_tdata, current_tdata;
   logic         voltage_tvalid, voltage_tready, voltage_tlast;
   logic         current_tvalid, current_tready, current_tlast;
   logic [2:0]   state_dbg;

   logic         man_drdy, resp_drdy, resp_en;
   logic [W-1:0] man_do, resp_do, resp_v_data, resp_c_data;
   logic [6:0]   addr_log [64];
   int           den_cnt = 0;
   int           n_cmp = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_v_q[$];
   logic [W-1:0] exp_c_q[$];

   assign xadc_drdy = man_drdy | resp_drdy;
   assign xadc_do   = man_drdy ? man_do : resp_do;

   always #5 clk = ~clk;

   xadc_drp_stream_adapter dut (
      .xadc_dclk      (clk),
      .xadc_reset     (xadc_reset),
      .xadc_daddr     (xadc_daddr),
      .xadc_den       (xadc_den),
      .xadc_drdy      (xadc_drdy),
      .xadc_do        (xadc_do),
      .xadc_eos       (xadc_eos),
      .voltage_tdata  (voltage_tdata),
      .voltage_tvalid (voltage_tvalid),
      .voltage_tready (voltage_tready),
      .voltage_tlast  (voltage_tlast),
      .current_tdata  (current_tdata),
      .current_tvalid (current_tvalid),
      .current_tready (current_tready),
      .current_tlast  (current_tlast),
      .state_dbg      (state_dbg)
   );

   // DRP responder: answers each den one cycle later with the channel's configured data.
   initial begin
      logic [W-1:0] d;
      resp_drdy = 1'b0;
      resp_do   = '0;
      forever begin
         @(negedge clk);
         if (resp_en && xadc_den) begin
            addr_log[den_cnt[5:0]] = xadc_daddr;
            den_cnt = den_cnt + 1;
            d = (xadc_daddr == 7'h14) ? resp_v_data : resp_c_data;
            @(posedge clk); #1;
            resp_drdy = 1'b1;
            resp_do   = d;
            @(posedge clk); #1;
            resp_drdy = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic hs_check();
      if (voltage_tvalid && voltage_tready) begin
         if (exp_v_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL v_hs_unexpected: got %h expected no beat", voltage_tdata);
         end else chk("v_hs", 32'(voltage_tdata), 32'(exp_v_q.pop_front()));
      end
      if (current_tvalid && current_tready) begin
         if (exp_c_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL c_hs_unexpected: got %h expected no beat", current_tdata);
         end else chk("c_hs", 32'(current_tdata), 32'(exp_c_q.pop_front()));
      end
   endtask

   task automatic drive_edge();
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [W-1:0] v_data, c_data;
      logic         v_ready, c_ready;
      int           v_hs_n;
      logic [W-1:0] v_hs0, v_hs1;
      int           c_hs_n;
      logic [W-1:0] c_hs0, c_hs1;
      logic         exp_v_valid;
      logic [W-1:0] exp_v_data;
      logic         exp_c_valid;
      logic [W-1:0] exp_c_data;
   } row_t;

   row_t rows [6];

   initial begin
      int base;
      rows[0] = '{16'h1234, 16'hABCD, 1'b1, 1'b1, 1, 16'h1234, 16'h0, 1, 16'hABCD, 16'h0,
                  1'b0, 16'h1234, 1'b0, 16'hABCD};
      rows[1] = '{16'h0001, 16'h5555, 1'b0, 1'b1, 0, 16'h0, 16'h0, 1, 16'h5555, 16'h0,
                  1'b1, 16'h0001, 1'b0, 16'h5555};
      rows[2] = '{16'h0002, 16'h6666, 1'b0, 1'b1, 0, 16'h0, 16'h0, 1, 16'h6666, 16'h0,
                  1'b1, 16'h0002, 1'b0, 16'h6666};
      rows[3] = '{16'h0003, 16'h7777, 1'b1, 1'b0, 2, 16'h0002, 16'h0003, 0, 16'h0, 16'h0,
                  1'b0, 16'h0003, 1'b1, 16'h7777};
      rows[4] = '{16'h00F0, 16'h8888, 1'b1, 1'b1, 1, 16'h00F0, 16'h0, 2, 16'h7777, 16'h8888,
                  1'b0, 16'h00F0, 1'b0, 16'h8888};
      rows[5] = '{16'h8000, 16'h0000, 1'b1, 1'b1, 1, 16'h8000, 16'h0, 1, 16'h0000, 16'h0,
                  1'b0, 16'h8000, 1'b0, 16'h0000};

      // ---- reset ----
      xadc_reset = 1'b1; xadc_eos = 1'b0; voltage_tready = 1'b0; current_tready = 1'b0;
      man_drdy = 1'b0; man_do = '0; resp_en = 1'b0; resp_v_data = '0; resp_c_data = '0;
      #1 xadc_reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_den", 32'(xadc_den), 0);
      chk("rst_daddr", 32'(xadc_daddr), 0);
      chk("rst_v_valid", 32'(voltage_tvalid), 0);
      chk("rst_c_valid", 32'(current_tvalid), 0);
      chk("rst_v_data", 32'(voltage_tdata), 0);
      chk("rst_c_data", 32'(current_tdata), 0);
      chk("tlast_v", 32'(voltage_tlast), 1);
      chk("tlast_c", 32'(current_tlast), 1);
      chk("rst_state", 32'(state_dbg), 0);
      drive_edge();
      xadc_reset = 1'b1;
      drive_edge(); drive_edge();
      @(negedge clk);
      chk("no_start_without_eos", 32'(xadc_den), 0);

      // ---- manual latency sequence ----
      drive_edge();
      xadc_eos = 1'b1;
      @(negedge clk);
      chk("den_before_eos_edge", 32'(xadc_den), 0);
      drive_edge();
      xadc_eos = 1'b0;
      @(negedge clk);
      chk("den_latency", 32'(xadc_den), 1);
      chk("daddr_v", 32'(xadc_daddr), 32'h14);
      chk("state_req_v", 32'(state_dbg), 1);
      drive_edge();
      @(negedge clk);
      chk("den_single_cycle", 32'(xadc_den), 0);
      chk("daddr_hold_v", 32'(xadc_daddr), 32'h14);
      drive_edge();
      man_drdy = 1'b1; man_do = 16'h1234;
      @(negedge clk);
      chk("v_valid_before_drdy_edge", 32'(voltage_tvalid), 0);
      drive_edge();
      man_drdy = 1'b0;
      @(negedge clk);
      chk("v_valid_latency", 32'(voltage_tvalid), 1);
      chk("v_data_capture", 32'(voltage_tdata), 32'h1234);
      chk("den_c", 32'(xadc_den), 1);
      chk("daddr_c", 32'(xadc_daddr), 32'h1C);
      drive_edge(); drive_edge();
      man_drdy = 1'b1; man_do = 16'hABCD;
      drive_edge();
      man_drdy = 1'b0;
      @(negedge clk);
      chk("c_valid_latency", 32'(current_tvalid), 1);
      chk("c_data_capture", 32'(current_tdata), 32'hABCD);
      chk("v_held_no_ready", 32'(voltage_tvalid), 1);
      chk("state_idle_after_c", 32'(state_dbg), 0);
      drive_edge();
      voltage_tready = 1'b1; current_tready = 1'b1;
      @(negedge clk);
      chk("v_valid_until_edge", 32'(voltage_tvalid), 1);
      drive_edge();
      @(negedge clk);
      chk("v_valid_cleared", 32'(voltage_tvalid), 0);
      chk("c_valid_cleared", 32'(current_tvalid), 0);

      // ---- spurious drdy in IDLE ----
      drive_edge();
      man_drdy = 1'b1; man_do = 16'hFFFF;
      drive_edge();
      man_drdy = 1'b0;
      @(negedge clk);
      chk("spur_v_valid", 32'(voltage_tvalid), 0);
      chk("spur_c_valid", 32'(current_tvalid), 0);
      chk("spur_v_data", 32'(voltage_tdata), 32'h1234);
      chk("spur_c_data", 32'(current_tdata), 32'hABCD);
      chk("spur_state", 32'(state_dbg), 0);

      // ---- table of full sequences with DRP responder ----
      drive_edge();
      resp_en = 1'b1;
      for (int r = 0; r < 6; r++) begin
         voltage_tready = rows[r].v_ready;
         current_tready = rows[r].c_ready;
         resp_v_data    = rows[r].v_data;
         resp_c_data    = rows[r].c_data;
         if (rows[r].v_hs_n > 0) exp_v_q.push_back(rows[r].v_hs0);
         if (rows[r].v_hs_n > 1) exp_v_q.push_back(rows[r].v_hs1);
         if (rows[r].c_hs_n > 0) exp_c_q.push_back(rows[r].c_hs0);
         if (rows[r].c_hs_n > 1) exp_c_q.push_back(rows[r].c_hs1);
         base = den_cnt;
         xadc_eos = 1'b1;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            hs_check();
            drive_edge();
            xadc_eos = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("row%0d_den_count", r), 32'(den_cnt - base), 2);
         chk($sformatf("row%0d_addr0", r), 32'(addr_log[base[5:0]]), 32'h14);
         chk($sformatf("row%0d_addr1", r), 32'(addr_log[6'(base + 1)]), 32'h1C);
         chk($sformatf("row%0d_v_beats_left", r), 32'(exp_v_q.size()), 0);
         chk($sformatf("row%0d_c_beats_left", r), 32'(exp_c_q.size()), 0);
         chk($sformatf("row%0d_v_valid", r), 32'(voltage_tvalid), 32'(rows[r].exp_v_valid));
         chk($sformatf("row%0d_v_data", r), 32'(voltage_tdata), 32'(rows[r].exp_v_data));
         chk($sformatf("row%0d_c_valid", r), 32'(current_tvalid), 32'(rows[r].exp_c_valid));
         chk($sformatf("row%0d_c_data", r), 32'(current_tdata), 32'(rows[r].exp_c_data));
         drive_edge();
      end

      // ---- second eos during WAIT_V: exactly one extra sequence ----
      voltage_tready = 1'b1; current_tready = 1'b1;
      resp_v_data = 16'h0A0A; resp_c_data = 16'h0B0B;
      exp_v_q.push_back(16'h0A0A); exp_v_q.push_back(16'h0A0A);
      exp_c_q.push_back(16'h0B0B); exp_c_q.push_back(16'h0B0B);
      base = den_cnt;
      xadc_eos = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         hs_check();
         if (i == 2) chk("eos_in_wait_v_state", 32'(state_dbg), 2);
         drive_edge();
         xadc_eos = (i == 1);
      end
      @(negedge clk);
      chk("merged_den_count", 32'(den_cnt - base), 4);
      chk("merged_addr2", 32'(addr_log[6'(base + 2)]), 32'h14);
      chk("merged_addr3", 32'(addr_log[6'(base + 3)]), 32'h1C);
      chk("merged_v_beats_left", 32'(exp_v_q.size()), 0);
      chk("merged_c_beats_left", 32'(exp_c_q.size()), 0);
      chk("merged_idle", 32'(state_dbg), 0);

      // ---- reset during WAIT_C ----
      drive_edge();
      resp_en = 1'b0; voltage_tready = 1'b0; current_tready = 1'b0;
      xadc_eos = 1'b1;
      drive_edge();
      xadc_eos = 1'b0;
      drive_edge();
      man_drdy = 1'b1; man_do = 16'h1111;
      drive_edge();
      man_drdy = 1'b0;
      drive_edge();
      @(negedge clk);
      chk("pre_rst_state_wait_c", 32'(state_dbg), 4);
      chk("pre_rst_v_valid", 32'(voltage_tvalid), 1);
      drive_edge();
      xadc_reset = 1'b0;
      #1;
      chk("midrst_den", 32'(xadc_den), 0);
      chk("midrst_v_valid", 32'(voltage_tvalid), 0);
      chk("midrst_c_valid", 32'(current_tvalid), 0);
      chk("midrst_v_data", 32'(voltage_tdata), 0);
      chk("midrst_c_data", 32'(current_tdata), 0);
      chk("midrst_state", 32'(state_dbg), 0);
      drive_edge();
      xadc_reset = 1'b1;
      man_drdy = 1'b1; man_do = 16'h2222;
      drive_edge();
      man_drdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_den", 32'(xadc_den), 0);
         chk("post_rst_c_valid", 32'(current_tvalid), 0);
         drive_edge();
      end
      chk("post_rst_c_data", 32'(current_tdata), 0);
      xadc_eos = 1'b1;
      drive_edge();
      xadc_eos = 1'b0;
      @(negedge clk);
      chk("post_rst_new_eos_den", 32'(xadc_den), 1);
      chk("post_rst_new_eos_addr", 32'(xadc_daddr), 32'h14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
